// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array result path.
// Contents: matrix geometry, accumulator/output widths, drain FSM state,
// element payload struct and a helper that builds a payload from a
// row-major element index.
package systolic_pkg;

  localparam int unsigned DIM     = 4;
  localparam int unsigned ACC_W   = 32;
  localparam int unsigned OUT_W   = 8;
  localparam int unsigned SHIFT_W = 5;
  localparam int unsigned IDX_W   = $clog2(DIM);
  localparam int unsigned N_ELEM  = DIM * DIM;
  localparam int unsigned CNT_W   = $clog2(N_ELEM);

  typedef enum logic {
    IDLE,
    DRAIN
  } drain_state_t;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [OUT_W-1:0] out_t;

  // One streamed element with its coordinates.
  typedef struct packed {
    out_t             data;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic             last;
  } drain_beat_t;

  // Row-major index -> payload; DIM is a power of two so row/col are bit fields.
  function automatic drain_beat_t make_beat(input out_t d, input logic [CNT_W-1:0] idx);
    drain_beat_t b;
    b.data = d;
    b.row  = idx[CNT_W-1:IDX_W];
    b.col  = idx[IDX_W-1:0];
    b.last = (idx == CNT_W'(N_ELEM - 1));
    return b;
  endfunction

endpackage

// File: rtl/systolic_result_drain_if.sv
// Element stream from the result drain to the next layer buffer.
// Signals: out_data (signed element), out_row/out_col (coordinates),
// out_last (final element of a matrix), out_valid/out_ready (handshake).
// master: drain side, slave: consumer side.
interface systolic_result_drain_if;
  import systolic_pkg::*;

  out_t             out_data;
  logic [IDX_W-1:0] out_row;
  logic [IDX_W-1:0] out_col;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data, out_row, out_col, out_last, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data, out_row, out_col, out_last, out_valid,
    output out_ready
  );

endinterface

// File: rtl/requant_sat.sv
// Combinational requantizer: arithmetic shift right with round-half-up,
// optional ReLU, then signed saturation to OUT_W bits.
// Ports: i_x (signed accumulator), i_shift (shift amount), o_y_c (result).
// Build option: DRAIN_RELU_EN forces negative results to zero before saturation.
module requant_sat
  import systolic_pkg::*;
(
  input  acc_t               i_x,
  input  logic [SHIFT_W-1:0] i_shift,
  output out_t               o_y_c
);

  localparam int SAT_HI_I = (1 <<< (OUT_W - 1)) - 1;
  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W + 1)'(SAT_HI_I);
  localparam logic signed [ACC_W:0] SAT_LO = (ACC_W + 1)'(-SAT_HI_I - 1);

  logic signed [ACC_W:0] w_ext;
  logic signed [ACC_W:0] w_bias;
  logic signed [ACC_W:0] w_sum;
  logic signed [ACC_W:0] w_y;
  logic signed [ACC_W:0] w_clip;

  // One extra bit keeps x + 2^(s-1) from wrapping at the positive limit.
  always_comb begin
    w_ext  = {i_x[ACC_W-1], i_x};
    w_bias = '0;
    if (i_shift != '0) begin
      w_bias = (ACC_W + 1)'(1) << (i_shift - SHIFT_W'(1));
    end
    w_sum  = w_ext + w_bias;
    w_y    = w_sum >>> i_shift;
    w_clip = w_y;
`ifdef DRAIN_RELU_EN
    if (w_y[ACC_W]) begin
      w_clip = '0;
    end
`endif
    if (w_clip > SAT_HI) begin
      w_clip = SAT_HI;
    end else if (w_clip < SAT_LO) begin
      w_clip = SAT_LO;
    end
    o_y_c = OUT_W'(w_clip);
  end

endmodule

// File: rtl/systolic_result_drain.sv
// Result drain for the scheduled DIMxDIM systolic array: snapshots the result
// matrix on i_computation_done, requantizes each element and streams them
// row-major over drain_if. o_busy holds off the array controller while
// undrained data remains; o_overrun flags a done strobe that was dropped.
// Ports: clk, rst_n (async, active-low), i_result_matrix, i_computation_done,
// i_cfg_shift, i_overrun_clr, drain_if (master), o_busy, o_overrun.
// Build option: DRAIN_RELU_EN (see requant_sat).
module systolic_result_drain
  import systolic_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  acc_t [DIM-1:0][DIM-1:0]      i_result_matrix,
  input  logic                         i_computation_done,
  input  logic [SHIFT_W-1:0]           i_cfg_shift,
  input  logic                         i_overrun_clr,
  systolic_result_drain_if.master      drain_if,
  output logic                         o_busy,
  output logic                         o_overrun
);

  drain_state_t        r_state, nxt_state;
  logic [CNT_W-1:0]    r_idx, nxt_idx;
  drain_beat_t         r_beat, nxt_beat;
  logic                r_valid, nxt_valid;
  logic                r_busy, nxt_busy;
  logic                r_overrun, nxt_overrun;
  logic [SHIFT_W-1:0]  r_shift;
  acc_t                r_buf [N_ELEM];

  logic                w_xfer;
  logic                w_last_xfer;
  logic                w_capture;
  logic                w_ovr_set;
  logic [CNT_W-1:0]    w_next_idx;
  acc_t                w_rq_x;
  logic [SHIFT_W-1:0]  w_rq_shift;
  out_t                w_rq_y;

  // A done strobe is accepted when idle or exactly on the final transfer.
  always_comb begin
    w_xfer      = r_valid & drain_if.out_ready;
    w_last_xfer = w_xfer & (r_idx == CNT_W'(N_ELEM - 1));
    w_capture   = i_computation_done & ((r_state == IDLE) | w_last_xfer);
    w_ovr_set   = i_computation_done & (r_state == DRAIN) & ~w_last_xfer;
    w_next_idx  = r_idx + CNT_W'(1);
  end

  // On capture element 0 comes straight from the inputs so it is valid next cycle.
  always_comb begin
    w_rq_x     = r_buf[w_next_idx];
    w_rq_shift = r_shift;
    if (w_capture) begin
      w_rq_x     = i_result_matrix[0][0];
      w_rq_shift = i_cfg_shift;
    end
  end

  requant_sat u_requant_sat (
    .i_x     (w_rq_x),
    .i_shift (w_rq_shift),
    .o_y_c   (w_rq_y)
  );

  // Next-state and registered-output logic.
  always_comb begin
    nxt_state   = r_state;
    nxt_idx     = r_idx;
    nxt_beat    = r_beat;
    nxt_valid   = r_valid;
    nxt_busy    = r_busy;
    nxt_overrun = r_overrun;

    case (r_state)
      IDLE:    if (w_capture) nxt_state = DRAIN;
      DRAIN:   if (w_last_xfer && !w_capture) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase

    if (w_capture) begin
      nxt_idx   = '0;
      nxt_beat  = make_beat(w_rq_y, '0);
      nxt_valid = 1'b1;
      nxt_busy  = 1'b1;
    end else if (w_last_xfer) begin
      nxt_valid     = 1'b0;
      nxt_busy      = 1'b0;
      nxt_beat.last = 1'b0;
    end else if (w_xfer) begin
      nxt_idx  = w_next_idx;
      nxt_beat = make_beat(w_rq_y, w_next_idx);
    end

    // Set has priority over a coincident clear.
    if (w_ovr_set) begin
      nxt_overrun = 1'b1;
    end else if (i_overrun_clr) begin
      nxt_overrun = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_beat    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      r_shift   <= '0;
    end else begin
      r_state   <= nxt_state;
      r_idx     <= nxt_idx;
      r_beat    <= nxt_beat;
      r_valid   <= nxt_valid;
      r_busy    <= nxt_busy;
      r_overrun <= nxt_overrun;
      if (w_capture) begin
        r_shift <= i_cfg_shift;
      end
    end
  end

  // Snapshot buffer; contents are irrelevant until the first capture.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int unsigned r = 0; r < DIM; r++) begin
        for (int unsigned c = 0; c < DIM; c++) begin
          r_buf[CNT_W'(r * DIM + c)] <= i_result_matrix[r][c];
        end
      end
    end
  end

  assign drain_if.out_data  = r_beat.data;
  assign drain_if.out_row   = r_beat.row;
  assign drain_if.out_col   = r_beat.col;
  assign drain_if.out_last  = r_beat.last;
  assign drain_if.out_valid = r_valid;
  assign o_busy             = r_busy;
  assign o_overrun          = r_overrun;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench for systolic_result_drain: directed matrices with
// hand-computed expectations pushed to a scoreboard; a negedge monitor pops
// and compares each accepted element and checks stability during stalls.
module tb_systolic_result_drain;
  import systolic_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  acc_t [DIM-1:0][DIM-1:0] matrix;
  logic                    done;
  logic [SHIFT_W-1:0]      cfg_shift;
  logic                    ovr_clr;
  logic                    busy;
  logic                    overrun;

  systolic_result_drain_if dif ();

  systolic_result_drain dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_result_matrix    (matrix),
    .i_computation_done (done),
    .i_cfg_shift        (cfg_shift),
    .i_overrun_clr      (ovr_clr),
    .drain_if           (dif),
    .o_busy             (busy),
    .o_overrun          (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int row;
    int col;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   n_xfer = 0;

  bit         stall_prev = 1'b0;
  int         held_data, held_row, held_col;
  bit         held_last;

  int m_id  [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
  int m_rnd [16] = '{5, -5, 6, -6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int m_sat [16] = '{1000, -1000, 127, -129, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int m_ov  [16] = '{41, 43, 45, 47, 49, 51, 53, 55, 57, 59, 61, 63, 65, 67, 69, 71};
  int e_ov  [16] = '{21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31, 32, 33, 34, 35, 36};
`ifdef DRAIN_RELU_EN
  int e_rnd1[16] = '{3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int e_rnd2[16] = '{1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int e_sat [16] = '{127, 0, 127, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
  int e_rnd1[16] = '{3, -2, 3, -3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int e_rnd2[16] = '{1, -1, 2, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int e_sat [16] = '{127, -128, 127, -128, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif

  // Scoreboard monitor: one comparison per accepted element, one per stalled cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        checks++;
        if (!dif.out_valid || int'(dif.out_data) != held_data || int'(dif.out_row) != held_row ||
            int'(dif.out_col) != held_col || dif.out_last != held_last) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b d=%0d r=%0d c=%0d l=%0b, want v=1 d=%0d r=%0d c=%0d l=%0b",
                   dif.out_valid, dif.out_data, dif.out_row, dif.out_col, dif.out_last,
                   held_data, held_row, held_col, held_last);
        end
      end
      if (dif.out_valid && dif.out_ready) begin
        n_xfer++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got d=%0d r=%0d c=%0d, want no element",
                   dif.out_data, dif.out_row, dif.out_col);
        end else begin
          e = exp_q.pop_front();
          if (int'(dif.out_data) != e.data || int'(dif.out_row) != e.row ||
              int'(dif.out_col) != e.col || dif.out_last != e.last) begin
            errors++;
            $display("FAIL sb_element: got d=%0d r=%0d c=%0d l=%0b, want d=%0d r=%0d c=%0d l=%0b",
                     dif.out_data, dif.out_row, dif.out_col, dif.out_last,
                     e.data, e.row, e.col, e.last);
          end
        end
      end
      stall_prev = dif.out_valid && !dif.out_ready;
      held_data  = int'(dif.out_data);
      held_row   = int'(dif.out_row);
      held_col   = int'(dif.out_col);
      held_last  = dif.out_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Drive a matrix with done for one cycle and queue its expected stream.
  task automatic load_issue(input int m[16], input int sh, input int ex[16]);
    for (int i = 0; i < 16; i++) begin
      matrix[i / DIM][i % DIM] = acc_t'(m[i]);
      exp_q.push_back('{ex[i], i / 4, i % 4, (i == 15)});
    end
    cfg_shift = SHIFT_W'(sh);
    done = 1'b1;
    @(posedge clk);
    #1 done = 1'b0;
  endtask

  // Done strobe whose data must never appear on the stream.
  task automatic pulse_drop(input bit with_clr);
    for (int i = 0; i < 16; i++) matrix[i / DIM][i % DIM] = acc_t'(99);
    done = 1'b1;
    ovr_clr = with_clr;
    @(posedge clk);
    #1 done = 1'b0;
    ovr_clr = 1'b0;
  endtask

  // Returns at the negedge before the n-th transfer of the current stream.
  task automatic wait_xfer(input int n, output bit ok);
    int cnt = 0;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (dif.out_valid && dif.out_ready) begin
        cnt++;
        if (cnt == n) begin
          ok = 1'b1;
          return;
        end
      end
    end
  endtask

  task automatic wait_last(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (dif.out_valid && dif.out_ready && dif.out_last) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    bit ok;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    done = 1'b0;
    cfg_shift = '0;
    ovr_clr = 1'b0;
    dif.out_ready = 1'b1;
    matrix = '0;

    #12;
    chk("rst_valid", int'(dif.out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_last", int'(dif.out_last), 0);
    chk("rst_data", int'(dif.out_data), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Identity stream, full throughput.
    load_issue(m_id, 0, m_id);
    chk("id_valid", int'(dif.out_valid), 1);
    chk("id_busy", int'(busy), 1);
    repeat (15) @(posedge clk);
    #1;
    chk("id_last_on_16th", int'(dif.out_last), 1);
    chk("id_busy_before_last", int'(busy), 1);
    @(posedge clk);
    #1;
    chk("id_busy_drop", int'(busy), 0);
    chk("id_valid_drop", int'(dif.out_valid), 0);

    // Rounding and saturation.
    load_issue(m_rnd, 1, e_rnd1);
    wait_idle(ok);
    chk("rnd1_done", int'(ok), 1);
    load_issue(m_rnd, 2, e_rnd2);
    wait_idle(ok);
    chk("rnd2_done", int'(ok), 1);
    load_issue(m_sat, 0, e_sat);
    wait_idle(ok);
    chk("sat_done", int'(ok), 1);

    // Backpressure with ready pattern 1,0,0,1.
    n_xfer = 0;
    load_issue(m_id, 0, m_id);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      dif.out_ready = pat[k % 4];
      @(posedge clk);
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    dif.out_ready = 1'b1;
    chk("bp_done", int'(ok), 1);
    chk("bp_count", n_xfer, 16);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Overrun: dropped done at transfer 5, coincident clear loses.
    load_issue(m_ov, 1, e_ov);
    wait_xfer(5, ok);
    chk("ov_reach5", int'(ok), 1);
    pulse_drop(1'b1);
    chk("ov_set_wins", int'(overrun), 1);
    chk("ov_busy", int'(busy), 1);
    wait_idle(ok);
    chk("ov_done", int'(ok), 1);
    chk("ov_sticky", int'(overrun), 1);
    ovr_clr = 1'b1;
    @(posedge clk);
    #1 ovr_clr = 1'b0;
    chk("ov_clr", int'(overrun), 0);

    // Back-to-back: done on the last transfer.
    load_issue(m_id, 0, m_id);
    wait_last(ok);
    chk("b2b_reach_last", int'(ok), 1);
    load_issue(m_rnd, 2, e_rnd2);
    chk("b2b_valid", int'(dif.out_valid), 1);
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_no_overrun", int'(overrun), 0);
    chk("b2b_row0", int'(dif.out_row), 0);
    chk("b2b_col0", int'(dif.out_col), 0);
    wait_idle(ok);
    chk("b2b_done", int'(ok), 1);

    // Reset during drain, then clean restart.
    load_issue(m_sat, 0, e_sat);
    wait_xfer(7, ok);
    chk("rm_reach7", int'(ok), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_valid", int'(dif.out_valid), 0);
    chk("rm_busy", int'(busy), 0);
    exp_q.delete();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    load_issue(m_id, 0, m_id);
    chk("rm_restart_data", int'(dif.out_data), 1);
    wait_idle(ok);
    chk("rm_restart_done", int'(ok), 1);

    chk("end_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
